// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: 2-FF sync + counter deglitch on SCL/SDA, edge and START/STOP detect, byte + ACK capture.
// Latency: pad change to edge/START/STOP pulse is 2+FILTER_LEN clk_i; rx_valid/ack_valid one cycle after the scl_rise pulse.
// Backpressure: none; a passive observer that emits single-cycle pulses and cannot stall the bus.
module i2c_bus_monitor #(
  parameter int FILTER_LEN = 3
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       en,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_rise,
  output logic       scl_fall,
  output logic       start_det,
  output logic       stop_det,
  output logic       bus_busy,
  output logic [3:0] bit_cnt,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ack,
  output logic       ack_valid
);

  localparam logic [3:0] LP_FLT = 4'(FILTER_LEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic [1:0] r_flt;
  logic [3:0] r_cnt [2];
  logic [1:0] w_tog;
  logic       w_start;
  logic       w_stop;

  logic       r_scl_rise;
  logic       r_scl_fall;
  logic       r_start_det;
  logic       r_stop_det;
  logic [1:0] r_state;
  logic       r_busy;
  logic [3:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_rx_ack;
  logic       r_ack_valid;

  // Two-flop synchronisers; they keep running while disabled so re-enable sees settled values.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 2'b11;
      r_s2 <= 2'b11;
    end else begin
      r_s1 <= {sda_i, scl_i};
      r_s2 <= r_s1;
    end
  end

  // A filtered line flips in the cycle its counter would reach FILTER_LEN.
  always_comb begin
    w_tog = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_tog[i] = en && (r_s2[i] != r_flt[i]) && ((r_cnt[i] + 4'd1) == LP_FLT);
    end
  end

  // Deglitch counters: count consecutive disagreeing cycles, clear on agreement.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_flt <= 2'b11;
      for (int i = 0; i < 2; i++) r_cnt[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!en) begin
          r_flt[i] <= 1'b1;
          r_cnt[i] <= 4'd0;
        end else if (r_s2[i] == r_flt[i]) begin
          r_cnt[i] <= 4'd0;
        end else if (w_tog[i]) begin
          r_flt[i] <= ~r_flt[i];
          r_cnt[i] <= 4'd0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 4'd1;
        end
      end
    end
  end

  // SDA moving while SCL is steady high is a bus condition; a simultaneous SCL change makes it a plain edge.
  assign w_start = w_tog[1] &  r_flt[1] & r_flt[0] & ~w_tog[0];
  assign w_stop  = w_tog[1] & ~r_flt[1] & r_flt[0] & ~w_tog[0];

  // Register the edge and condition pulses alongside the filtered value update.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_rise  <= 1'b0;
      r_scl_fall  <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
    end else begin
      r_scl_rise  <= w_tog[0] & ~r_flt[0];
      r_scl_fall  <= w_tog[0] &  r_flt[0];
      r_start_det <= w_start;
      r_stop_det  <= w_stop;
    end
  end

  // Frame tracker: STOP beats START beats data; partial bytes are dropped on either condition.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 7'd0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_rx_ack    <= 1'b1;
      r_ack_valid <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_ack_valid <= 1'b0;
      if (!en || r_stop_det) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_bit_cnt <= 4'd0;
        r_shift   <= 7'd0;
      end else if (r_start_det) begin
        r_state   <= S_DATA;
        r_busy    <= 1'b1;
        r_bit_cnt <= 4'd0;
        r_shift   <= 7'd0;
      end else if (r_scl_rise) begin
        case (r_state)
          S_DATA: begin
            r_shift   <= {r_shift[5:0], r_flt[1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              r_rx_data  <= {r_shift, r_flt[1]};
              r_rx_valid <= 1'b1;
              r_state    <= S_ACK;
            end
          end
          S_ACK: begin
            r_rx_ack    <= r_flt[1];
            r_ack_valid <= 1'b1;
            r_bit_cnt   <= 4'd0;
            r_state     <= S_DATA;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign scl_rise  = r_scl_rise;
  assign scl_fall  = r_scl_fall;
  assign start_det = r_start_det;
  assign stop_det  = r_stop_det;
  assign bus_busy  = r_busy;
  assign bit_cnt   = r_bit_cnt;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign rx_ack    = r_rx_ack;
  assign ack_valid = r_ack_valid;

endmodule

// File: doc/i2c_bus_monitor.md
Name: i2c_bus_monitor

Overview:
Receive-side counterpart to the I2C clock divisor. Samples external SCL/SDA on the high-speed system clock, synchronises and deglitches them, and detects SCL edges and START/STOP conditions. Shifts in bytes MSB-first plus the ACK bit. Feeds the controller's slave/monitor path and its bus-busy arbitration.

Parameters:
FILTER_LEN, 3, number of consecutive clk_i cycles a synchronised line must differ from its filtered value before the filtered value changes (1..15).

Ports:
clk_i  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  monitor enable
scl_i  input  1  raw SCL from pad
sda_i  input  1  raw SDA from pad
scl_rise  output  1  one-cycle pulse, filtered SCL rising edge
scl_fall  output  1  one-cycle pulse, filtered SCL falling edge
start_det  output  1  one-cycle pulse, START or repeated START detected
stop_det  output  1  one-cycle pulse, STOP detected
bus_busy  output  1  high from START until STOP
bit_cnt  output  4  bits received in current frame, 0..8
rx_data  output  8  last complete byte, MSB first
rx_valid  output  1  one-cycle pulse, rx_data updated
rx_ack  output  1  sampled 9th bit (0 = ACK, 1 = NACK)
ack_valid  output  1  one-cycle pulse, rx_ack updated

Behaviour:
- Reset is asynchronous, active-low. Sync flops and filtered SCL/SDA reset to 1 (idle bus). All pulses, bus_busy, bit_cnt and rx_data reset to 0. rx_ack resets to 1. FSM resets to IDLE.
- Synchroniser: 2-FF per line.
- Filter: one 4-bit counter per line.
  - Counter clears whenever the synced value equals the filtered value; otherwise it increments.
  - When the counter reaches FILTER_LEN, the filtered value toggles and the counter clears.
  - Latency from pad change to filtered change is 2+FILTER_LEN clk_i cycles.
  - Pulses shorter than FILTER_LEN cycles are suppressed.
- Edges: scl_rise/scl_fall are registered. Each is high for exactly the one cycle after filtered SCL changes.
- START/STOP conditions:
  - START: filtered SDA 1->0 while filtered SCL is 1 and SCL did not change in the same cycle.
  - STOP: filtered SDA 0->1 under the same condition.
  - Both pulse one cycle, aligned with the edge-pulse timing.
  - If SCL and SDA change in the same cycle, the event is an SCL edge only; no START/STOP.
- FSM states: IDLE, DATA, ACK.
  - IDLE: bus_busy=0, bit_cnt=0. START moves to DATA and sets bus_busy=1.
  - DATA: on each scl_rise, shift filtered SDA into the shift register (MSB first) and increment bit_cnt.
    - On the 8th rise: rx_data <= completed byte, rx_valid pulses the next cycle, and the FSM moves to ACK.
  - ACK: on scl_rise, rx_ack <= filtered SDA, ack_valid pulses the next cycle, bit_cnt <= 0, and the FSM returns to DATA.
  - START in DATA or ACK (repeated START) stays in or returns to DATA. bit_cnt <= 0, the partial byte is discarded, no rx_valid, bus_busy stays 1.
  - STOP in any state goes to IDLE. bus_busy <= 0, bit_cnt <= 0, the partial byte is discarded. rx_data and rx_ack are held.
- SDA changes while SCL is low are data setup only: no event.
- bit_cnt range is 0..8. It never wraps past 8.
- en=0:
  - Synchronisers keep running.
  - Filter counters clear and filtered values are forced to 1.
  - FSM goes to IDLE with bus_busy=0; all pulses are 0; rx_data and rx_ack are held.
- After en rises: edges and START/STOP detection follow normal filter latency. bus_busy only sets on the next START, so a transfer already in progress is ignored until then.
- Reset mid-frame returns immediately to reset values.

Test Plan:
- FILTER_LEN=3. START, byte 0xA5 at 8 clk_i per SCL half-period, ACK=0, STOP -> start_det 1 pulse; 8 scl_rise; rx_valid 1 pulse with rx_data=0xA5; ack_valid with rx_ack=0; stop_det; bus_busy 1 from START to STOP.
- 2-cycle glitch low on SCL while high during a byte -> no scl_fall/scl_rise; bit_cnt unchanged. A 3-cycle glitch -> one fall and one rise pulse each.
- START, 5 bits 10110, repeated START, byte 0x3C, NACK -> second start_det; bit_cnt returns to 0; no rx_valid for the partial byte; rx_data=0x3C; rx_ack=1; bus_busy never drops.
- STOP after 4 bits of byte -> stop_det, bus_busy=0, bit_cnt=0, no rx_valid, rx_data retains previous value.
- SCL and SDA driven 1->0 in the same clk_i cycle -> scl_fall only, no start_det.
- en deasserted mid-byte, re-enabled while bus active -> bus_busy=0 and no rx_valid until next START; following byte 0xFF received correctly; async rst_n pulse mid-byte -> all outputs at reset values the same cycle.
